// File: rtl/pe_mac_responder_if.sv
// Handshake and data bundle between the PE controller (master) and the MAC responder datapath (slave).
interface pe_mac_responder_if #(
  parameter int DW = 16,
  parameter int AW = 36
);
  logic                 inready;
  logic                 krnready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic signed [DW-1:0] krn_re;
  logic signed [DW-1:0] krn_im;
  logic                 mulvalid;
  logic                 rdfifo;
  logic signed [AW-1:0] psum_re;
  logic signed [AW-1:0] psum_im;
  logic                 outready;
  logic signed [AW-1:0] out_re;
  logic signed [AW-1:0] out_im;
  logic                 out_valid;
  logic                 busy;
  logic                 err;

  modport master (
    output inready, krnready, in_re, in_im, krn_re, krn_im, rdfifo, psum_re, psum_im, outready,
    input  mulvalid, out_re, out_im, out_valid, busy, err
  );

  modport slave (
    input  inready, krnready, in_re, in_im, krn_re, krn_im, rdfifo, psum_re, psum_im, outready,
    output mulvalid, out_re, out_im, out_valid, busy, err
  );
endinterface

// File: rtl/pe_mac_responder.sv
// PE datapath responder: one complex multiply per operand pair, saturating add of a psum, result held for write-back.
module pe_mac_responder #(
  parameter int DW     = 16,
  parameter int AW     = 36,
  parameter int MULLAT = 3
) (
  input logic               clk,
  input logic               rstn,
  pe_mac_responder_if.slave bus
);
  localparam int PW = 2 * DW + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_HOLD = 3'd2,
    ST_PSUM = 3'd3,
    ST_ADD  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  state_e                 state_r, next_state_s;
  logic [2:0]             cnt_r;
  logic signed [DW-1:0]   a_re_r, a_im_r, b_re_r, b_im_r;
  logic signed [2*DW-1:0] rr_s, ii_s, ri_s, ir_s;
  logic signed [PW-1:0]   prod_re_s, prod_im_s, prod_re_r, prod_im_r;
  logic signed [AW-1:0]   psum_re_r, psum_im_r, out_re_r, out_im_r;
  logic signed [AW:0]     sum_re_s, sum_im_s;
  logic                   capture_s, viol_s, mul_done_s;
  logic                   mulvalid_r, out_valid_r, busy_r, err_r;

  function automatic logic signed [AW-1:0] sat_fn(input logic signed [AW:0] v);
    logic signed [AW-1:0] r;
    if (v[AW] != v[AW-1]) begin
      r = v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      r = v[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [PW-1:0] sext_prod(input logic signed [2*DW-1:0] p);
    return {p[2*DW-1], p};
  endfunction

  // Exact complex product from the captured operands, one guard bit wide.
  assign rr_s      = a_re_r * b_re_r;
  assign ii_s      = a_im_r * b_im_r;
  assign ri_s      = a_re_r * b_im_r;
  assign ir_s      = a_im_r * b_re_r;
  assign prod_re_s = sext_prod(rr_s) - sext_prod(ii_s);
  assign prod_im_s = sext_prod(ri_s) + sext_prod(ir_s);

  assign sum_re_s = {{(AW+1-PW){prod_re_r[PW-1]}}, prod_re_r} + {psum_re_r[AW-1], psum_re_r};
  assign sum_im_s = {{(AW+1-PW){prod_im_r[PW-1]}}, prod_im_r} + {psum_im_r[AW-1], psum_im_r};

  assign mul_done_s = (state_r == ST_MUL) && (cnt_r == 3'd0);

  // Any strobe arriving in a state that cannot accept it is a violation; it is otherwise ignored.
  assign viol_s = ((bus.inready || bus.krnready) && (state_r != ST_IDLE))
               || ((bus.inready ^ bus.krnready) && (state_r == ST_IDLE))
               || (bus.rdfifo && (state_r != ST_HOLD))
               || (bus.outready && (state_r != ST_DONE));

  // Next-state decode and operand-capture strobe.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.inready && bus.krnready) begin
          capture_s    = 1'b1;
          next_state_s = ST_MUL;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == 3'd0) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      ST_HOLD: begin
        if (bus.rdfifo) begin
          next_state_s = ST_PSUM;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_PSUM: next_state_s = ST_ADD;
      ST_ADD:  next_state_s = ST_DONE;
      ST_DONE: begin
        if (bus.outready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r       <= 3'd0;
      a_re_r      <= '0;
      a_im_r      <= '0;
      b_re_r      <= '0;
      b_im_r      <= '0;
      prod_re_r   <= '0;
      prod_im_r   <= '0;
      psum_re_r   <= '0;
      psum_im_r   <= '0;
      out_re_r    <= '0;
      out_im_r    <= '0;
      mulvalid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (capture_s) begin
        a_re_r <= bus.in_re;
        a_im_r <= bus.in_im;
        b_re_r <= bus.krn_re;
        b_im_r <= bus.krn_im;
        cnt_r  <= 3'(MULLAT - 1);
      end else if ((state_r == ST_MUL) && (cnt_r != 3'd0)) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if (mul_done_s) begin
        prod_re_r <= prod_re_s;
        prod_im_r <= prod_im_s;
      end
      if (state_r == ST_PSUM) begin
        psum_re_r <= bus.psum_re;
        psum_im_r <= bus.psum_im;
      end
      if (state_r == ST_ADD) begin
        out_re_r <= sat_fn(sum_re_s);
        out_im_r <= sat_fn(sum_im_s);
      end
      out_valid_r <= (state_r == ST_DONE) && bus.outready;
      mulvalid_r  <= (next_state_s == ST_HOLD);
      busy_r      <= (next_state_s != ST_IDLE);
      err_r       <= err_r | viol_s;
    end
  end

  assign bus.mulvalid  = mulvalid_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_re    = out_re_r;
  assign bus.out_im    = out_im_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_pe_mac_responder.sv
// Randomized scoreboard bench for pe_mac_responder against a plain-arithmetic complex MAC model.
module tb_pe_mac_responder;
  localparam int     DW     = 16;
  localparam int     AW     = 36;
  localparam int     MULLAT = 3;
  localparam longint MAXV   = 64'sd34359738367;
  localparam longint MINV   = -64'sd34359738368;

  typedef struct {
    longint re;
    longint im;
  } res_t;

  logic   clk    = 1'b0;
  logic   rstn   = 1'b0;
  int     n_cmp  = 0;
  int     n_mis  = 0;
  int     pulses = 0;
  int     pushed = 0;
  logic   prev_ov = 1'b0;
  res_t   exp_q[$];
  longint cur_ar, cur_ai, cur_br, cur_bi;

  pe_mac_responder_if #(.DW(DW), .AW(AW)) bus ();

  pe_mac_responder #(.DW(DW), .AW(AW), .MULLAT(MULLAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic res_t model(input longint ar, ai, br, bi, psr, psi);
    res_t r;
    r.re = clamp(ar * br - ai * bi + psr);
    r.im = clamp(ar * bi + ai * br + psi);
    return r;
  endfunction

  function automatic longint rnd_op();
    logic [31:0]          t;
    logic signed [DW-1:0] s;
    t = $urandom();
    s = t[DW-1:0];
    case ($urandom_range(0, 4))
      0:       return -64'sd32768;
      1:       return 64'sd32767;
      default: return longint'(s);
    endcase
  endfunction

  function automatic longint rnd_psum();
    logic [63:0]          t;
    logic signed [AW-1:0] s;
    t = {$urandom(), $urandom()};
    s = t[AW-1:0];
    case ($urandom_range(0, 5))
      0:       return MAXV;
      1:       return MINV;
      default: return longint'(s);
    endcase
  endfunction

  // Scoreboard monitor: every out_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.out_valid) begin
        pulses++;
        chk("out_valid_single_cycle", longint'(prev_ov), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_out_valid: got pulse, expected none");
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb_out_re", longint'(bus.out_re), e.re);
          chk("sb_out_im", longint'(bus.out_im), e.im);
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic idle_inputs();
    bus.inready  = 1'b0;
    bus.krnready = 1'b0;
    bus.rdfifo   = 1'b0;
    bus.outready = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    bus.krn_re   = '0;
    bus.krn_im   = '0;
    bus.psum_re  = '0;
    bus.psum_im  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mulvalid", longint'(bus.mulvalid), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_err", longint'(bus.err), 0);
    chk("rst_out_re", longint'(bus.out_re), 0);
    chk("rst_out_im", longint'(bus.out_im), 0);
    rstn = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge where mulvalid is seen.
  task automatic start_op(input longint ar, ai, br, bi);
    int k;
    cur_ar = ar; cur_ai = ai; cur_br = br; cur_bi = bi;
    bus.inready  = 1'b1;
    bus.krnready = 1'b1;
    bus.in_re    = ar[DW-1:0];
    bus.in_im    = ai[DW-1:0];
    bus.krn_re   = br[DW-1:0];
    bus.krn_im   = bi[DW-1:0];
    @(posedge clk);
    @(negedge clk);
    bus.inready  = 1'b0;
    bus.krnready = 1'b0;
    k = 0;
    while (!bus.mulvalid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("mulvalid_latency", k, MULLAT);
  endtask

  task automatic read_psum(input longint psr, psi);
    res_t e;
    logic [63:0] junk;
    bus.rdfifo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rdfifo  = 1'b0;
    bus.psum_re = psr[AW-1:0];
    bus.psum_im = psi[AW-1:0];
    chk("mulvalid_drop", longint'(bus.mulvalid), 0);
    e = model(cur_ar, cur_ai, cur_br, cur_bi, psr, psi);
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    @(negedge clk);
    junk = {$urandom(), $urandom()};
    bus.psum_re = junk[AW-1:0];
    bus.psum_im = junk[63:64-AW];
    @(posedge clk);
    @(negedge clk);
    chk("out_re_at_r2", longint'(bus.out_re), e.re);
    chk("out_im_at_r2", longint'(bus.out_im), e.im);
    chk("busy_in_done", longint'(bus.busy), 1);
  endtask

  task automatic finish_op(input bit collide);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.outready = 1'b1;
    if (collide) begin
      bus.inready  = 1'b1;
      bus.krnready = 1'b1;
      bus.in_re    = 16'sd100;
      bus.krn_re   = 16'sd7;
    end
    @(posedge clk);
    @(negedge clk);
    bus.outready = 1'b0;
    bus.inready  = 1'b0;
    bus.krnready = 1'b0;
    chk("busy_after_write", longint'(bus.busy), 0);
  endtask

  task automatic full_op(input longint ar, ai, br, bi, psr, psi, input bit collide);
    start_op(ar, ai, br, bi);
    read_psum(psr, psi);
    finish_op(collide);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    full_op(3, 4, 2, -1, 10, -5, 1'b0);
    full_op(32767, 0, 32767, 0, MAXV, MINV, 1'b0);
    full_op(-32768, -32768, -32768, 32767, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      full_op(rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_psum(), rnd_psum(), 1'b0);
    end
    chk("err_clean_run", longint'(bus.err), 0);

    // Lone inready in IDLE: flagged, nothing captured.
    bus.inready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inready = 1'b0;
    chk("err_lone_inready", longint'(bus.err), 1);
    repeat (4) @(negedge clk);
    chk("no_capture_mulvalid", longint'(bus.mulvalid), 0);
    chk("no_capture_busy", longint'(bus.busy), 0);
    do_reset();

    // rdfifo in IDLE, then err must survive a clean operation.
    bus.rdfifo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rdfifo = 1'b0;
    chk("err_rdfifo_idle", longint'(bus.err), 1);
    @(negedge clk);
    full_op(rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_psum(), rnd_psum(), 1'b0);
    chk("err_sticky", longint'(bus.err), 1);
    do_reset();

    // Write strobe together with new operands: write completes, operands dropped.
    full_op(5, -6, 7, 8, 1000, -1000, 1'b1);
    chk("err_collide", longint'(bus.err), 1);
    repeat (2) @(negedge clk);
    chk("collide_no_mulvalid", longint'(bus.mulvalid), 0);
    do_reset();

    // Asynchronous reset while holding a product.
    start_op(rnd_op(), rnd_op(), rnd_op(), rnd_op());
    #2 rstn = 1'b0;
    #1;
    chk("rst_hold_mulvalid", longint'(bus.mulvalid), 0);
    chk("rst_hold_busy", longint'(bus.busy), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    full_op(-123, 456, 789, -1011, 12345, -67890, 1'b0);
    chk("err_after_rst_op", longint'(bus.err), 0);

    repeat (3) @(negedge clk);
    chk("pulse_count", pulses, pushed);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pe_mac_responder.md
Name: pe_mac_responder

Overview:
- Datapath end of the PE control protocol: responds to the PE controller's operand-ready strobes (inready/krnready), the multiply-valid handshake (mulvalid), psum FIFO reads (rdfifo) and the write strobe (outready).
- Performs one complex frequency-domain multiply per operand pair, then adds the product to a partial sum from the psum FIFO.
- Presents the result for write-back.
- Sits between the input/kernel buffers and psum FIFO on one side and the PE controller on the other.

Parameters:
- DW, 16: signed width of each real/imag operand component.
- AW, 36: signed accumulator/psum component width; AW >= 2*DW+1 required.
- MULLAT, 3: multiply pipeline latency in cycles, from capture to mulvalid; range 1..7.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- inready  in  1  input operand on in_re/in_im valid this cycle.
- krnready  in  1  kernel operand on krn_re/krn_im valid this cycle.
- in_re, in_im  in  DW each  input spectrum sample, two's complement.
- krn_re, krn_im  in  DW each  kernel spectrum sample.
- mulvalid  out  1  product ready; level signal.
- rdfifo  in  1  controller pops psum FIFO this cycle.
- psum_re, psum_im  in  AW each  FIFO data, valid the cycle after rdfifo.
- outready  in  1  controller write strobe; consumes the result.
- out_re, out_im  out  AW each  accumulated result.
- out_valid  out  1  one-cycle pulse, the cycle after outready is accepted.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rstn low): state IDLE, pipeline flushed. mulvalid=0, out_valid=0, busy=0, err=0, out_re=out_im=0, internal product and sum registers cleared. Reset mid-operation abandons the operation with no output.
- States:
  - IDLE: inready&krnready both high in the same cycle capture both operands and go to MUL. Exactly one of them high sets err; no capture.
  - MUL: counts MULLAT cycles. Product is then registered, go to HOLD.
  - HOLD: mulvalid=1. rdfifo -> PSUM, mulvalid drops the same edge.
  - PSUM: psum_re/im sampled this cycle -> ADD.
  - ADD: sum = sext(product) + psum per component, saturating to the AW signed range -> DONE.
  - DONE: sum held on out_re/out_im. outready -> out_valid=1 next cycle, go to IDLE.
- Arithmetic:
  - pr = ar*br - ai*bi; pi = ar*bi + ai*br.
  - Exact at 2*DW+1 bits, then sign-extended to AW.
  - Saturation on the add only: overflow clamps to +(2^(AW-1)-1) or -2^(AW-1), independently per component.
- Latency: capture at edge N → mulvalid high from edge N+MULLAT.
  - rdfifo at edge R → sum valid on out_* from edge R+2.
  - out_valid at outready edge +1.
- Protocol violations (set err, otherwise ignored; state unchanged):
  - inready or krnready high outside IDLE.
  - rdfifo outside HOLD.
  - outready outside DONE.
- Simultaneous events:
  - outready in DONE together with inready&krnready: the write completes; operands are NOT captured and err is set.
  - The controller must wait one cycle before issuing new operands.
- out_re/out_im keep their last value after out_valid until the next ADD.

Test Plan:
- Reset, then capture in=(3,4), krn=(2,-1) → mulvalid exactly MULLAT=3 cycles later. After rdfifo with psum=(10,-5): out=(20,0), out_valid 1 cycle after outready, busy low after.
- Saturation: in=(32767,0), krn=(32767,0), psum=(2^35-1, -2^35) → out_re=2^35-1, out_im=-2^35.
- Negative extremes: in=(-32768,-32768), krn=(-32768,32768-1), psum=0 → exact pr/pi values, no wrap.
- Protocol errors:
  - inready without krnready in IDLE → err=1, no capture, mulvalid stays 0.
  - rdfifo in IDLE → err=1.
  - err stays high until reset.
- Reset asserted while in HOLD → mulvalid=0 immediately (async), state IDLE. A subsequent clean operation produces the correct result.
- Back-to-back: two operations with one idle cycle between → two out_valid pulses with independent correct sums, err=0.
